// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target at a fixed 7-bit address with a byte-wide core interface
module i2c_target #(
    parameter logic [6:0] ADDR = 7'b1010110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
    } state_t;

    logic   scl_s1_q, scl_s2_q, scl_prev_q, sda_s1_q, sda_s2_q, sda_prev_q;
    logic   scl_s1_d, scl_s2_d, scl_prev_d, sda_s1_d, sda_s2_d, sda_prev_d;
    state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic   done_q, done_d;
    logic [7:0] shift_q, shift_d;
    logic   rw_q, rw_d;
    logic   sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic   rx_valid_q, rx_valid_d, tx_req_q, tx_req_d, busy_q, busy_d;
    logic   scl_rise, scl_fall, start_det, stop_det;

    // START/STOP require SCL high on both samples, so an SCL edge always wins
    assign scl_rise  = scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q & scl_prev_q;
    assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;

    always_comb begin
        scl_s1_d   = scl;
        scl_s2_d   = scl_s1_q;
        scl_prev_d = scl_s2_q;
        sda_s1_d   = sda;
        sda_s2_d   = sda_s1_q;
        sda_prev_d = sda_s2_q;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        done_d     = done_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = 3'd0;
            done_d    = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (scl_rise) begin
            // done marks the 8th sampled bit; the byte is acted on at the following fall
            case (state_q)
                S_ADDR, S_WRITE, S_READ: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) done_d = 1'b1;
                    if (state_q != S_READ) shift_d = {shift_q[6:0], sda_s2_q};
                end
                S_READ_ACK: begin
                    if (sda_s2_q) begin
                        state_d = S_IGNORE;
                        busy_d  = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                S_ADDR: begin
                    if (done_q) begin
                        done_d = 1'b0;
                        if (shift_q[7:1] == ADDR) begin
                            state_d  = S_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                            if (shift_q[0]) begin
                                tx_req_d = 1'b1;
                                shift_d  = tx_data;
                            end
                        end else begin
                            state_d = S_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    state_d  = rw_q ? S_READ : S_WRITE;
                    sda_oe_d = rw_q & ~shift_q[7];
                end
                S_WRITE: begin
                    if (done_q) begin
                        done_d     = 1'b0;
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        sda_oe_d   = 1'b1;
                        state_d    = S_WRITE_ACK;
                    end
                end
                S_WRITE_ACK: begin
                    sda_oe_d = 1'b0;
                    state_d  = S_WRITE;
                end
                S_READ: begin
                    if (done_q) begin
                        done_d   = 1'b0;
                        sda_oe_d = 1'b0;
                        state_d  = S_READ_ACK;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                S_READ_ACK: begin
                    if (done_q) begin
                        done_d   = 1'b0;
                        tx_req_d = 1'b1;
                        shift_d  = tx_data;
                        sda_oe_d = ~tx_data[7];
                        state_d  = S_READ;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            done_q     <= 1'b0;
            shift_q    <= 8'd0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_s1_q   <= scl_s1_d;
            scl_s2_q   <= scl_s2_d;
            scl_prev_q <= scl_prev_d;
            sda_s1_q   <= sda_s1_d;
            sda_s2_q   <= sda_s2_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            done_q     <= done_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - bus-level bench for i2c_target driving a bit-banged controller
module tb_i2c_target;
    localparam logic [6:0] ADDR = 7'b1010110;
    localparam int PH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] tx_data = 8'd0;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, busy;

    int total = 0;
    int bad = 0;
    int rx_cnt = 0, tx_cnt = 0, wide_cnt = 0;
    logic rx_prev = 1'b0, tx_prev = 1'b0, busy_seen = 1'b0, tgt_drove = 1'b0;
    logic [7:0] rx_log[$];

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_target #(.ADDR(ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_req(tx_req), .busy(busy)
    );

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            rx_log.push_back(rx_data);
        end
        if (tx_req === 1'b1) tx_cnt++;
        if ((rx_valid === 1'b1 && rx_prev) || (tx_req === 1'b1 && tx_prev)) wide_cnt++;
        rx_prev = (rx_valid === 1'b1);
        tx_prev = (tx_req === 1'b1);
        if (busy === 1'b1) busy_seen = 1'b1;
        if (m_sda && sda === 1'b0) tgt_drove = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        rx_cnt = 0;
        tx_cnt = 0;
        rx_log.delete();
        busy_seen = 1'b0;
        tgt_drove = 1'b0;
    endtask

    task automatic bus_start;
        m_sda = 1'b1; wait_clk(4);
        scl = 1'b1;   wait_clk(PH);
        m_sda = 1'b0; wait_clk(PH);
        scl = 1'b0;   wait_clk(2);
    endtask

    task automatic bus_stop;
        m_sda = 1'b0; wait_clk(6);
        scl = 1'b1;   wait_clk(PH);
        m_sda = 1'b1; wait_clk(PH);
    endtask

    task automatic put_bit(input logic b);
        m_sda = b;  wait_clk(6);
        scl = 1'b1; wait_clk(PH);
        scl = 1'b0; wait_clk(2);
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; wait_clk(6);
        scl = 1'b1;   wait_clk(PH / 2);
        b = sda;      wait_clk(PH / 2);
        scl = 1'b0;   wait_clk(2);
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] d, input logic ack, input logic [7:0] next_tx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        tx_data = next_tx;
        put_bit(ack);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; scl = 1'b1; m_sda = 1'b1;
        wait_clk(3);
        total++; if (rx_data !== 8'd0) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL reset_tx_req got=%b exp=0", tx_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (sda !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b exp=1", sda); end
        rst_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_write;
        logic a;
        clear_mon();
        bus_start();
        put_byte({ADDR, 1'b0}, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL wr_addr_ack got=%b exp=0", a); end
        put_byte(8'hAA, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL wr_data_ack got=%b exp=0", a); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", busy); end
        bus_stop();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_stop got=%b exp=0", busy); end
        total++; if (rx_cnt != 1) begin bad++; $display("FAIL wr_rx_count got=%0d exp=1", rx_cnt); end
        total++; if (rx_data !== 8'hAA) begin bad++; $display("FAIL wr_rx_data got=%h exp=aa", rx_data); end
    endtask

    task automatic test_read;
        logic a;
        logic [7:0] d;
        clear_mon();
        tx_data = 8'h3C;
        bus_start();
        put_byte({ADDR, 1'b1}, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL rd_addr_ack got=%b exp=0", a); end
        total++; if (tx_cnt != 1) begin bad++; $display("FAIL rd_tx_req_count got=%0d exp=1", tx_cnt); end
        get_byte(d, 1'b1, 8'h00);
        total++; if (d !== 8'h3C) begin bad++; $display("FAIL rd_data got=%h exp=3c", d); end
        wait_clk(4);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_nack got=%b exp=0", busy); end
        total++; if (sda !== 1'b1) begin bad++; $display("FAIL rd_sda_released got=%b exp=1", sda); end
        bus_stop();
        total++; if (tx_cnt != 1) begin bad++; $display("FAIL rd_no_second_req got=%0d exp=1", tx_cnt); end
    endtask

    task automatic test_wrong_addr;
        logic a;
        clear_mon();
        bus_start();
        put_byte({7'b0010001, 1'b0}, a);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL na_addr_ack got=%b exp=1", a); end
        put_byte(8'h55, a);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL na_data_ack got=%b exp=1", a); end
        bus_stop();
        total++; if (rx_cnt != 0) begin bad++; $display("FAIL na_rx_count got=%0d exp=0", rx_cnt); end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL na_busy got=%b exp=0", busy_seen); end
        total++; if (tgt_drove !== 1'b0) begin bad++; $display("FAIL na_sda_driven got=%b exp=0", tgt_drove); end
    endtask

    task automatic test_multi_write;
        logic a;
        logic [7:0] bytes [3];
        logic [7:0] got;
        bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'hFF;
        clear_mon();
        bus_start();
        put_byte({ADDR, 1'b0}, a);
        for (int i = 0; i < 3; i++) begin
            put_byte(bytes[i], a);
            total++; if (a !== 1'b0) begin bad++; $display("FAIL mw_ack%0d got=%b exp=0", i, a); end
        end
        bus_stop();
        total++; if (rx_cnt != 3) begin bad++; $display("FAIL mw_rx_count got=%0d exp=3", rx_cnt); end
        for (int i = 0; i < 3; i++) begin
            got = (i < rx_log.size()) ? rx_log[i] : 8'hxx;
            total++; if (got !== bytes[i]) begin bad++; $display("FAIL mw_byte%0d got=%h exp=%h", i, got, bytes[i]); end
        end
    endtask

    task automatic test_repeated_start;
        logic a;
        logic [7:0] d;
        clear_mon();
        bus_start();
        put_byte({ADDR, 1'b0}, a);
        put_byte(8'h77, a);
        tx_data = 8'hC3;
        bus_start();
        put_byte({ADDR, 1'b1}, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL rs_addr_ack got=%b exp=0", a); end
        get_byte(d, 1'b1, 8'h00);
        total++; if (d !== 8'hC3) begin bad++; $display("FAIL rs_read got=%h exp=c3", d); end
        bus_stop();
        total++; if (rx_cnt != 1) begin bad++; $display("FAIL rs_rx_count got=%0d exp=1", rx_cnt); end
        total++; if (tx_cnt != 1) begin bad++; $display("FAIL rs_tx_count got=%0d exp=1", tx_cnt); end
    endtask

    task automatic test_reset_mid;
        logic a;
        logic [7:0] got;
        clear_mon();
        bus_start();
        put_byte({ADDR, 1'b0}, a);
        put_byte(8'h96, a);
        for (int i = 0; i < 4; i++) put_bit(1'b1 ^ i[0]);
        m_sda = 1'b1;
        rst_n = 1'b0;
        wait_clk(2);
        total++; if (rx_data !== 8'd0) begin bad++; $display("FAIL rm_rx_data got=%h exp=00", rx_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
        total++; if (rx_valid !== 1'b0 || tx_req !== 1'b0) begin bad++; $display("FAIL rm_pulses got=%b%b exp=00", rx_valid, tx_req); end
        total++; if (sda !== 1'b1) begin bad++; $display("FAIL rm_sda got=%b exp=1", sda); end
        total++; if (rx_cnt != 1) begin bad++; $display("FAIL rm_rx_count got=%0d exp=1", rx_cnt); end
        rst_n = 1'b1;
        wait_clk(4);
        clear_mon();
        bus_start();
        put_byte({ADDR, 1'b0}, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL rm_addr_ack got=%b exp=0", a); end
        put_byte(8'h5A, a);
        bus_stop();
        got = (rx_log.size() > 0) ? rx_log[0] : 8'hxx;
        total++; if (rx_cnt != 1 || got !== 8'h5A) begin bad++; $display("FAIL rm_rewrite got=%h/%0d exp=5a/1", got, rx_cnt); end
    endtask

    task automatic test_random;
        logic a, match, rw;
        logic [6:0] addr;
        logic [7:0] d, got;
        logic [7:0] data [4];
        int n, exp_rx, exp_tx;
        for (int t = 0; t < 10; t++) begin
            match = ($urandom_range(0, 3) != 0);
            rw = $urandom_range(0, 1);
            n = $urandom_range(1, 3);
            addr = 7'($urandom);
            if (!match && addr == ADDR) addr = addr ^ 7'h01;
            if (match) addr = ADDR;
            for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
            exp_rx = (match && !rw) ? n : 0;
            exp_tx = (match && rw) ? n : 0;
            clear_mon();
            tx_data = data[0];
            bus_start();
            put_byte({addr, rw}, a);
            total++; if (a !== !match) begin bad++; $display("FAIL rnd%0d_addr_ack got=%b exp=%b", t, a, !match); end
            if (rw && match) begin
                for (int i = 0; i < n; i++) begin
                    get_byte(d, (i == n - 1), data[i + 1]);
                    total++; if (d !== data[i]) begin bad++; $display("FAIL rnd%0d_rd%0d got=%h exp=%h", t, i, d, data[i]); end
                end
            end else if (!rw) begin
                for (int i = 0; i < n; i++) begin
                    put_byte(data[i], a);
                    total++; if (a !== !match) begin bad++; $display("FAIL rnd%0d_wack%0d got=%b exp=%b", t, i, a, !match); end
                end
            end
            bus_stop();
            total++; if (rx_cnt != exp_rx) begin bad++; $display("FAIL rnd%0d_rx_count got=%0d exp=%0d", t, rx_cnt, exp_rx); end
            total++; if (tx_cnt != exp_tx) begin bad++; $display("FAIL rnd%0d_tx_count got=%0d exp=%0d", t, tx_cnt, exp_tx); end
            total++; if (busy_seen !== match) begin bad++; $display("FAIL rnd%0d_busy_seen got=%b exp=%b", t, busy_seen, match); end
            for (int i = 0; i < exp_rx; i++) begin
                got = (i < rx_log.size()) ? rx_log[i] : 8'hxx;
                total++; if (got !== data[i]) begin bad++; $display("FAIL rnd%0d_rx%0d got=%h exp=%h", t, i, got, data[i]); end
            end
        end
    endtask

    task automatic test_pulse_width;
        total++; if (wide_cnt != 0) begin bad++; $display("FAIL pulse_width got=%0d exp=0", wide_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL final_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrong_addr();
        test_multi_write();
        test_repeated_start();
        test_reset_mid();
        test_random();
        test_pulse_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

Clock-synchronous I2C target (slave) at fixed 7-bit address. Pairs with `i2c_controller` on the same two-wire bus.
- Oversamples SCL/SDA on the system clock and decodes START/STOP.
- Acknowledges its own address; deserialises write bytes and serialises read bytes.
- Sits between the bus pins and a simple byte-wide register/FIFO interface on the core side.

## Interface
- `ADDR`, 7'b1010110, target address matched against first byte after START.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `scl`  input  1  bus clock from controller; target never stretches.
- `sda`  inout  1  bus data, open-drain: drives 0 or z only, never 1.
- `rx_data`  output  8  last byte received in a write transfer.
- `rx_valid`  output  1  one-cycle pulse: `rx_data` updated.
- `tx_data`  input  8  byte to return in a read transfer; sampled on `tx_req`.
- `tx_req`  output  1  one-cycle pulse: `tx_data` captured this cycle.
- `busy`  output  1  high from START with matching address until STOP or mismatch.

## Operation
- Input conditioning: 2-FF synchronizer on `scl` and `sda`. One further register per signal gives previous value. Edges are computed from synchronized current vs previous.
- START: sync SDA falls while sync SCL high. Accepted in every state, including a repeated START mid-transfer. Action: clear bit counter, release SDA, go to ADDR.
- STOP: sync SDA rises while sync SCL high. Action: go to IDLE from any state, release SDA, clear `busy`.
- Bit sampling: SDA sampled on SCL rising edge, MSB first. Target changes its SDA drive only on SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
    - On 8th falling edge with match: if W go to ADDR_ACK and pull SDA low; if R go to ADDR_ACK, pull SDA low, pulse `tx_req` and load shift register from `tx_data`.
    - On mismatch: go to IGNORE, SDA released.
  - ADDR_ACK: on next falling edge release SDA. Then go to WRITE, or to READ with driving MSB of shift register.
  - WRITE: shift 8 bits. On 8th falling edge: `rx_data` <= byte, pulse `rx_valid`, pull SDA low, go to WRITE_ACK.
  - WRITE_ACK: on falling edge release SDA, go to WRITE.
  - READ: drive shift register MSB-first (0 -> pull low, 1 -> release), updating on each falling edge. After 8th falling edge release SDA, go to READ_ACK.
  - READ_ACK: sample on rising edge.
    - SDA=0 (ACK): on falling edge pulse `tx_req`, reload from `tx_data`, drive MSB, go to READ.
    - SDA=1 (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Multi-byte transfers are unbounded; bit counter is 3 bits and wraps 7->0 at each byte boundary.
- Non-match: never drives SDA, no `rx_valid`, no `tx_req`, `busy` stays 0.

## Timing
- Reset (`rst_n`=0 at a clock edge): state IDLE, SDA released (z), `rx_data`=0, `rx_valid`=0, `tx_req`=0, `busy`=0, synchronizer regs=1 (idle bus). Reset mid-transfer abandons the byte with no pulses. After reset the target waits for a fresh START.
- Edge-detect latency: 3 `clk` cycles from pin change to event.
- Bus requirement: SCL high and low phases each ≥ 4 `clk` cycles. SDA must be stable ≥ 4 `clk` cycles around SCL edges.
- SDA drive change: 3–4 `clk` after SCL falling pin edge; well inside the low phase.
- `rx_valid` and `tx_req`: exactly 1 cycle wide, coincident with the qualifying SCL falling-edge event.
- `tx_data` must be valid on the `tx_req` cycle; the value is held internally thereafter.
- `busy`: set on the cycle the address-match decision is made; cleared on the STOP/mismatch/NACK cycle.
- START and STOP detected in the same cycle cannot occur, since both need an SDA edge. SCL and SDA edges in the same cycle: SCL edge is processed, and no START/STOP is flagged.

## Test plan
- Write with controller (`addr`=7'b1010110, `rw`=0, `data_in`=8'hAA): ACK low on 9th SCL after address and after data; `rx_data`=8'hAA; exactly one `rx_valid` pulse; `busy` drops at STOP.
- Read (`rw`=1, `tx_data`=8'h3C): one `tx_req` after address ACK; bus bits 0,0,1,1,1,1,0,0. Controller NACK -> IGNORE, SDA released, no second `tx_req`.
- Wrong address 7'b0010001, write 8'h55: SDA never driven by target, 9th bit reads 1, `rx_valid`/`busy` stay 0.
- Three-byte write 8'h01,8'h80,8'hFF: three `rx_valid` pulses with matching `rx_data`, three data ACKs (counter wrap).
- Repeated START after one write byte, then read with `tx_data`=8'hC3: returns 8'hC3; no spurious `rx_valid`.
- `rst_n`=0 for 2 cycles mid-data-byte: all outputs at reset values next cycle, SDA z; following full write of 8'h5A received correctly.
